// File: rtl/systolic_matmul_nxn_if.sv
// Operand, result and status bundle for the NxN systolic multiplier.
// master = feeder/writeback side, slave = the array.
interface systolic_matmul_nxn_if #(
  parameter int N     = 4,
  parameter int DW    = 16,
  parameter int ACC_W = 32,
  parameter int K_MAX = 256
);
  localparam int KW = $clog2(K_MAX + 1);
  localparam int RW = $clog2(N);

  logic              start;
  logic              clear_acc;
  logic [KW-1:0]     k_len;
  logic              in_valid;
  logic              in_ready;
  logic [N*DW-1:0]   a_vec;
  logic [N*DW-1:0]   b_vec;
  logic              out_valid;
  logic              out_ready;
  logic [RW-1:0]     out_row;
  logic [N*ACC_W-1:0] out_data;
  logic              busy;
  logic              done;

  modport master (
    output start, clear_acc, k_len, in_valid, a_vec, b_vec, out_ready,
    input  in_ready, out_valid, out_row, out_data, busy, done
  );

  modport slave (
    input  start, clear_acc, k_len, in_valid, a_vec, b_vec, out_ready,
    output in_ready, out_valid, out_row, out_data, busy, done
  );
endinterface

// File: rtl/systolic_matmul_nxn.sv
// Output-stationary NxN systolic matrix multiplier, C = A(NxK) * B(KxN).
// One k-slice enters per beat; lanes are skewed internally so PE(i,j)
// consumes beat k at (accept edge + i + j + 1). C drains one row per beat.
module systolic_matmul_nxn #(
  parameter int N      = 4,
  parameter int DW     = 16,
  parameter int ACC_W  = 32,
  parameter int K_MAX  = 256,
  parameter int SIGNED = 1
) (
  input logic                  clk,
  input logic                  rst,
  systolic_matmul_nxn_if.slave bus
);
  localparam int KW = $clog2(K_MAX + 1);
  localparam int RW = $clog2(N);
  localparam int FW = $clog2(2 * N);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  state_t             state_q;
  logic [KW-1:0]      k_len_q;
  logic [KW-1:0]      beat_cnt_q;
  logic [FW-1:0]      flush_cnt_q;
  logic [RW-1:0]      row_q;
  logic [RW-1:0]      row_d;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               done_q;
  logic [N*ACC_W-1:0] out_data_q;

  // Skew lines: lane i is read at stage i (i+1 registers deep)
  logic [DW-1:0]      a_sk_q  [N][N];
  logic               a_skv_q [N][N];
  logic [DW-1:0]      b_sk_q  [N][N];
  logic               b_skv_q [N][N];

  // Inter-PE operand registers: A moves right, B moves down
  logic [DW-1:0]      a_pe_q  [N][N-1];
  logic               a_pev_q [N][N-1];
  logic [DW-1:0]      b_pe_q  [N-1][N];
  logic               b_pev_q [N-1][N];
  logic [ACC_W-1:0]   acc_q   [N][N];

  logic [DW-1:0]      a_in  [N][N];
  logic               av_in [N][N];
  logic [DW-1:0]      b_in  [N][N];
  logic               bv_in [N][N];

  logic beat_fire, start_go, clear_go, load_en;

  assign beat_fire = bus.in_valid & in_ready_q;
  assign start_go  = (state_q == IDLE) & bus.start & (bus.k_len != '0);
  assign clear_go  = start_go & bus.clear_acc;
  assign row_d     = out_valid_q ? row_q + RW'(1) : '0;
  assign load_en   = (state_q == DRAIN) &&
                     (!out_valid_q || (bus.out_ready && (row_q != RW'(N - 1))));

  // Full-precision product, sign- or zero-extended (or truncated) to ACC_W
  function automatic logic [ACC_W-1:0] mul_ext(input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
    logic signed [2*DW-1:0]       ax, bx, p;
    logic signed [2*DW+ACC_W-1:0] w;
    if (SIGNED != 0) begin
      ax = {{DW{a[DW-1]}}, a};
      bx = {{DW{b[DW-1]}}, b};
    end else begin
      ax = {{DW{1'b0}}, a};
      bx = {{DW{1'b0}}, b};
    end
    p = ax * bx;
    if (SIGNED != 0) w = {{ACC_W{p[2*DW-1]}}, p};
    else             w = {{ACC_W{1'b0}}, p};
    return w[ACC_W-1:0];
  endfunction

  // Route each PE's operands: edge PEs take skew outputs, others a neighbour
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_in[i][0]  = a_sk_q[i][i];
      av_in[i][0] = a_skv_q[i][i];
      for (int j = 1; j < N; j++) begin
        a_in[i][j]  = a_pe_q[i][j-1];
        av_in[i][j] = a_pev_q[i][j-1];
      end
    end
    for (int j = 0; j < N; j++) begin
      b_in[0][j]  = b_sk_q[j][j];
      bv_in[0][j] = b_skv_q[j][j];
      for (int i = 1; i < N; i++) begin
        b_in[i][j]  = b_pe_q[i-1][j];
        bv_in[i][j] = b_pev_q[i-1][j];
      end
    end
  end

  // Input skew: capture the accepted beat with a valid tag, then delay
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int l = 0; l < N; l++) begin
        for (int s = 0; s < N; s++) begin
          a_sk_q[l][s] <= '0; a_skv_q[l][s] <= 1'b0;
          b_sk_q[l][s] <= '0; b_skv_q[l][s] <= 1'b0;
        end
      end
    end else begin
      for (int l = 0; l < N; l++) begin
        a_sk_q[l][0]  <= bus.a_vec[l*DW +: DW];
        a_skv_q[l][0] <= beat_fire;
        b_sk_q[l][0]  <= bus.b_vec[l*DW +: DW];
        b_skv_q[l][0] <= beat_fire;
        for (int s = 1; s < N; s++) begin
          a_sk_q[l][s]  <= a_sk_q[l][s-1];
          a_skv_q[l][s] <= a_skv_q[l][s-1];
          b_sk_q[l][s]  <= b_sk_q[l][s-1];
          b_skv_q[l][s] <= b_skv_q[l][s-1];
        end
      end
    end
  end

  // Systolic hops and accumulation; bubbles (invalid tags) leave sums alone
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) acc_q[i][j] <= '0;
        for (int j = 0; j < N - 1; j++) begin
          a_pe_q[i][j] <= '0; a_pev_q[i][j] <= 1'b0;
          b_pe_q[j][i] <= '0; b_pev_q[j][i] <= 1'b0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N - 1; j++) begin
          a_pe_q[i][j]  <= a_in[i][j];
          a_pev_q[i][j] <= av_in[i][j];
          b_pe_q[j][i]  <= b_in[j][i];
          b_pev_q[j][i] <= bv_in[j][i];
        end
        for (int j = 0; j < N; j++) begin
          if (clear_go)                      acc_q[i][j] <= '0;
          else if (av_in[i][j] && bv_in[i][j]) acc_q[i][j] <= acc_q[i][j] + mul_ext(a_in[i][j], b_in[i][j]);
        end
      end
    end
  end

  // Result row register: loads row 0 on entering DRAIN, next row per handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data_q <= '0;
    end else if (load_en) begin
      for (int j = 0; j < N; j++) out_data_q[j*ACC_W +: ACC_W] <= acc_q[row_d][j];
    end
  end

  // Job sequencer IDLE -> LOAD -> FLUSH (2N-1 cycles) -> DRAIN -> IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      k_len_q     <= '0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
      row_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_go) begin
            state_q    <= LOAD;
            k_len_q    <= bus.k_len;
            beat_cnt_q <= '0;
            in_ready_q <= 1'b1;
          end
        end
        LOAD: begin
          if (beat_fire) begin
            beat_cnt_q <= beat_cnt_q + KW'(1);
            if (beat_cnt_q == k_len_q - KW'(1)) begin
              state_q     <= FLUSH;
              in_ready_q  <= 1'b0;
              flush_cnt_q <= '0;
            end
          end
        end
        FLUSH: begin
          flush_cnt_q <= flush_cnt_q + FW'(1);
          if (flush_cnt_q == FW'(2 * N - 2)) state_q <= DRAIN;
        end
        DRAIN: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            row_q       <= '0;
          end else if (bus.out_ready) begin
            if (row_q == RW'(N - 1)) begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
              row_q       <= '0;
              done_q      <= 1'b1;
            end else begin
              row_q <= row_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_row   = row_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
endmodule
